// File: rtl/pc_stack.sv
// pc_stack: program counter with relative branch, call/return stack, stall and illegal-op error pulse
//   clk, rst        : clock, synchronous active-high reset
//   en              : 0 stalls every state update
//   op, data        : operation select and its operand (target address or signed branch offset)
//   out             : registered program counter
//   depth           : registered count of valid return addresses
//   empty, full     : registered stack status, updated together with depth
//   err             : one-cycle pulse after an illegal CALL, RET or reserved opcode
module pc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int STEP = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             data,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);
    localparam int DW = $clog2(DEPTH+1);
    // Storage rounded up to a power of two so depth_q indexes it directly at full width.
    localparam int SLOTS = 1 << DW;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    typedef enum logic [2:0] {
        OP_HOLD, OP_INC, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET
    } op_e;
    logic [WIDTH-1:0] out_q, out_d, ret_addr;
    logic [DW-1:0]    depth_q, depth_d;
    logic             empty_q, full_q, err_q, err_d;
    logic             call_ok, ret_ok;
    logic [WIDTH-1:0] stack_q [SLOTS];
    always_comb begin
        ret_addr = out_q + STEP_W;
        call_ok  = en && op == OP_CALL && !full_q;
        ret_ok   = en && op == OP_RET && !empty_q;
        err_d    = en && (op[2:1] == 2'b11 || (op == OP_CALL && full_q) || (op == OP_RET && empty_q));
        // Branch offset is the same width as the PC, so a plain add is the sign-extended modular add.
        out_d    = !en               ? out_q :
                   op == OP_INC      ? ret_addr :
                   op == OP_LOAD     ? data :
                   op == OP_BRANCH   ? out_q + data :
                   call_ok           ? data :
                   ret_ok            ? stack_q[depth_q - DW'(1)] : out_q;
        depth_d  = call_ok ? depth_q + DW'(1) : ret_ok ? depth_q - DW'(1) : depth_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= RESET_VAL;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            empty_q <= depth_d == '0;
            full_q  <= depth_d == DW'(DEPTH);
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && call_ok) stack_q[depth_q] <= ret_addr;
    end
    assign out   = out_q;
    assign depth = depth_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign err   = err_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: scoreboard bench for pc_stack (WIDTH=8, DEPTH=4, STEP=1, RESET_VAL=0)
module tb_pc_stack;
    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                           CALL = 3'd4, RET = 3'd5, RSV6 = 3'd6, RSV7 = 3'd7;
    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b1;
    logic [2:0] op = HOLD;
    logic [7:0] data = '0;
    logic [7:0] out;
    logic [2:0] depth;
    logic       empty, full, err;
    int vectors = 0, miscompares = 0;
    // expected/observed layout: {out[7:0], depth[2:0], empty, full, err}
    logic [13:0] sbq[$];
    logic [13:0] got, exp_v;
    logic [7:0]  m_out = '0;
    logic [7:0]  m_stk[$];
    logic        m_err = 1'b0;
    pc_stack #(.WIDTH(8), .DEPTH(4), .STEP(1), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .data(data),
        .out(out), .depth(depth), .empty(empty), .full(full), .err(err)
    );
    always #5 clk = ~clk;
    task automatic apply(input logic r, input logic e, input logic [2:0] o, input logic [7:0] d);
        rst = r; en = e; op = o; data = d;
        m_err = 1'b0;
        if (r) begin
            m_out = 8'h00;
            m_stk.delete();
        end else if (e) begin
            case (o)
                INC:    m_out = m_out + 8'd1;
                LOAD:   m_out = d;
                BRANCH: m_out = m_out + d;
                CALL:   if (m_stk.size() == 4) m_err = 1'b1;
                        else begin m_stk.push_back(m_out + 8'd1); m_out = d; end
                RET:    if (m_stk.size() == 0) m_err = 1'b1;
                        else m_out = m_stk.pop_back();
                HOLD:   m_err = 1'b0;
                default: m_err = 1'b1;
            endcase
        end
        sbq.push_back({m_out, 3'(m_stk.size()), m_stk.size() == 0, m_stk.size() == 4, m_err});
        @(posedge clk);
        #1;
        got = {out, depth, empty, full, err};
    endtask
    task automatic test_reset;
        apply(1, 1, LOAD, 8'h55);
        apply(1, 1, LOAD, 8'h55);
        exp_v = sbq.pop_front(); sbq.pop_front();
        vectors++;
        if (got !== exp_v || out !== 8'h00 || empty !== 1'b1 || err !== 1'b0) begin
            miscompares++; $display("FAIL reset got %h required %h", got, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, i == 0 ? LOAD : INC, 8'hFE);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || out !== 8'hFE + 8'(i) || err !== 1'b0) begin
                miscompares++; $display("FAIL inc_wrap[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_branch;
        logic [7:0] offs[3] = '{8'h10, 8'h05, 8'hF0};
        logic [7:0] want[3] = '{8'h10, 8'h15, 8'h05};
        for (int i = 0; i < 6; i++) begin
            apply(0, i < 3, i == 0 ? LOAD : i < 3 ? BRANCH : INC, offs[i < 3 ? i : 0]);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || out !== want[i < 3 ? i : 2]) begin
                miscompares++; $display("FAIL branch_stall[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_nested;
        logic [2:0] ops[5]  = '{LOAD, CALL, CALL, RET, RET};
        logic [7:0] dat[5]  = '{8'h20, 8'h40, 8'h60, 8'h00, 8'h00};
        logic [7:0] want[5] = '{8'h20, 8'h40, 8'h60, 8'h41, 8'h21};
        logic [2:0] wdep[5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, ops[i], dat[i]);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || out !== want[i] || depth !== wdep[i]) begin
                miscompares++; $display("FAIL nested[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_overflow;
        apply(0, 1, LOAD, 8'h00);
        sbq.pop_front();
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1, CALL, 8'(i));
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || full !== (i == 4)) begin
                miscompares++; $display("FAIL fill[%0d] got %h required %h", i, got, exp_v);
            end
        end
        apply(0, 1, CALL, 8'h99);
        exp_v = sbq.pop_front(); vectors++;
        if (got !== exp_v || err !== 1'b1 || out !== 8'h04 || depth !== 3'd4) begin
            miscompares++; $display("FAIL overflow got %h required %h", got, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, RET, 8'h00);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || out !== 8'(4 - i) || err !== 1'b0) begin
                miscompares++; $display("FAIL drain[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_errors;
        logic [2:0] ops[5] = '{RET, RSV6, INC, RSV7, RSV7};
        logic       ens[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       werr[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(0, ens[i], ops[i], 8'hAA);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || err !== werr[i] || depth !== 3'd0) begin
                miscompares++; $display("FAIL err_ops[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_back_to_back;
        logic [2:0] ops[6]  = '{LOAD, CALL, RET, CALL, CALL, RET};
        logic [7:0] dat[6]  = '{8'hFF, 8'hFF, 8'h00, 8'h80, 8'h90, 8'h00};
        logic [7:0] want[6] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 8'h90, 8'h81};
        for (int i = 0; i < 6; i++) begin
            apply(0, 1, ops[i], dat[i]);
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v || out !== want[i]) begin
                miscompares++; $display("FAIL back_to_back[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    task automatic test_reset_mid;
        apply(0, 1, CALL, 8'h30);
        apply(0, 1, CALL, 8'h40);
        apply(1, 1, RET, 8'h00);
        sbq.pop_front(); sbq.pop_front(); exp_v = sbq.pop_front(); vectors++;
        if (got !== exp_v || out !== 8'h00 || depth !== 3'd0 || empty !== 1'b1) begin
            miscompares++; $display("FAIL reset_mid got %h required %h", got, exp_v);
        end
        apply(0, 1, RET, 8'h00);
        exp_v = sbq.pop_front(); vectors++;
        if (got !== exp_v || err !== 1'b1) begin
            miscompares++; $display("FAIL ret_after_reset got %h required %h", got, exp_v);
        end
    endtask
    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 60) == 0, $urandom_range(0, 5) != 0,
                  3'($urandom_range(0, 7)), 8'($urandom));
            exp_v = sbq.pop_front(); vectors++;
            if (got !== exp_v) begin
                miscompares++; $display("FAIL random[%0d] got %h required %h", i, got, exp_v);
            end
        end
    endtask
    initial begin
        test_reset;
        test_branch;
        test_nested;
        test_overflow;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
